// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the processing element:
//   MODE_PASS / MODE_ACC : i_mode encoding
//   sat_res_t            : clamped value plus clamp flag
//   sat_add()            : signed add followed by a clamp to an out_bw-bit
//                          signed range; out_bw is a run-time argument so a
//                          single function serves any parameterisation
// ----------------------------------------------------------------------------
package pe_pkg;

   localparam logic MODE_PASS = 1'b0;
   localparam logic MODE_ACC  = 1'b1;

   typedef struct packed {
      logic        sat;
      logic [63:0] val;
   } sat_res_t;

   // Operands are sign-extended to 64 bits by the caller. That is wide enough
   // for the sum never to wrap before the clamp.
   function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int unsigned        out_bw);
      logic signed [63:0] sum;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      sum = a + b;
      hi  = (64'sd1 <<< (out_bw - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (out_bw - 1));
      if (sum > hi) begin
         r.sat = 1'b1;
         r.val = hi;
      end else if (sum < lo) begin
         r.sat = 1'b1;
         r.val = lo;
      end else begin
         r.sat = 1'b0;
         r.val = sum;
      end
      return r;
   endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// ----------------------------------------------------------------------------
// pe_weight_bank
// Per-PE weight register file, loaded over the shared broadcast write bus.
//   clk, rst   : clock, synchronous active-high reset (clears all banks)
//   w_en       : write strobe
//   w_addr     : target element address; only ELEMENT_ADDR is accepted
//   w_bank     : target bank; indices >= NUM_BANKS are ignored
//   w_data     : signed weight
//   rd_bank    : bank read by the current compute beat
//   rd_data    : registered weight of rd_bank (0 when rd_bank >= NUM_BANKS)
// The read returns the registered value, so a write in the same cycle is not
// seen until the following cycle.
// ----------------------------------------------------------------------------
module pe_weight_bank #(
   parameter int WEIGHT_BW    = 8,
   parameter int ADDR_BW      = 5,
   parameter int ELEMENT_ADDR = 0,
   parameter int NUM_BANKS    = 4,
   parameter int BANK_BW      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        w_en,
   input  logic [ADDR_BW-1:0]          w_addr,
   input  logic [BANK_BW-1:0]          w_bank,
   input  logic signed [WEIGHT_BW-1:0] w_data,
   input  logic [BANK_BW-1:0]          rd_bank,
   output logic signed [WEIGHT_BW-1:0] rd_data
);

   localparam logic [ADDR_BW-1:0] MY_ADDR = ADDR_BW'(ELEMENT_ADDR);

   logic signed [WEIGHT_BW-1:0] bank_q [NUM_BANKS];
   logic signed [WEIGHT_BW-1:0] bank_d [NUM_BANKS];
   logic                        wr_hit;
   logic                        rd_ok;

   always_comb begin
      wr_hit = w_en && (w_addr == MY_ADDR) && (32'(w_bank) < NUM_BANKS);
      rd_ok  = (32'(rd_bank) < NUM_BANKS);
      bank_d = bank_q;
      if (wr_hit) bank_d[w_bank] = w_data;
      rd_data = rd_ok ? bank_q[rd_bank] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) bank_q <= '{default: '0};
      else     bank_q <= bank_d;
   end

endmodule

// File: rtl/processing_element_mc.sv
// ----------------------------------------------------------------------------
// processing_element_mc
// Conv-array PE: banked weights, 2-stage valid-qualified MAC, two modes.
//   clk, rst            : clock, synchronous active-high reset
//   i_w_en/addr/bank/w  : broadcast weight write bus
//   i_valid             : compute beat valid (0 = bubble)
//   i_bank_sel          : weight bank for this beat
//   i_mode              : MODE_PASS (psum + w*x) or MODE_ACC (framed sum)
//   i_first / i_last    : accumulate frame delimiters
//   i_x                 : signed activation
//   i_psum              : chained psum (pass) or bias on first beat (acc)
//   o_valid             : one-cycle pulse per result, 2 cycles after the beat
//   o_psum / o_sat      : saturated result and clamp flag, held between pulses
// ----------------------------------------------------------------------------
module processing_element_mc
   import pe_pkg::*;
#(
   parameter int WEIGHT_BW    = 8,
   parameter int DATA_BW      = 8,
   parameter int SUM_BW       = 16,
   parameter int ADDR_BW      = 5,
   parameter int ELEMENT_ADDR = 0,
   parameter int NUM_BANKS    = 4,
   parameter int BANK_BW      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_w_en,
   input  logic [ADDR_BW-1:0]          i_w_addr,
   input  logic [BANK_BW-1:0]          i_w_bank,
   input  logic signed [WEIGHT_BW-1:0] i_w,
   input  logic                        i_valid,
   input  logic [BANK_BW-1:0]          i_bank_sel,
   input  logic                        i_mode,
   input  logic                        i_first,
   input  logic                        i_last,
   input  logic signed [DATA_BW-1:0]   i_x,
   input  logic signed [SUM_BW-1:0]    i_psum,
   output logic                        o_valid,
   output logic signed [SUM_BW:0]      o_psum,
   output logic                        o_sat
);

   localparam int          PROD_BW = WEIGHT_BW + DATA_BW;
   localparam int unsigned OUT_BW  = SUM_BW + 1;

   logic signed [WEIGHT_BW-1:0] w_rd;
   logic signed [PROD_BW-1:0]   prod_c;

   logic                        s1_valid_q, s1_valid_d;
   logic signed [PROD_BW-1:0]   s1_prod_q,  s1_prod_d;
   logic signed [SUM_BW-1:0]    s1_psum_q,  s1_psum_d;
   logic                        s1_mode_q,  s1_mode_d;
   logic                        s1_first_q, s1_first_d;
   logic                        s1_last_q,  s1_last_d;

   logic signed [SUM_BW:0]      acc_q, acc_d;
   logic                        sticky_q, sticky_d;
   logic                        o_valid_q, o_valid_d;
   logic signed [SUM_BW:0]      o_psum_q, o_psum_d;
   logic                        o_sat_q, o_sat_d;

   logic signed [SUM_BW:0]      acc_base;
   sat_res_t                    pass_r;
   sat_res_t                    acc_r;
   logic                        unused_hi_bits;

   pe_weight_bank #(
      .WEIGHT_BW    (WEIGHT_BW),
      .ADDR_BW      (ADDR_BW),
      .ELEMENT_ADDR (ELEMENT_ADDR),
      .NUM_BANKS    (NUM_BANKS),
      .BANK_BW      (BANK_BW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .w_en    (i_w_en),
      .w_addr  (i_w_addr),
      .w_bank  (i_w_bank),
      .w_data  (i_w),
      .rd_bank (i_bank_sel),
      .rd_data (w_rd)
   );

   // Stage 1: capture the product and beat attributes; bubbles hold state.
   always_comb begin
      prod_c     = PROD_BW'(w_rd) * PROD_BW'(i_x);
      s1_valid_d = i_valid;
      s1_prod_d  = s1_prod_q;
      s1_psum_d  = s1_psum_q;
      s1_mode_d  = s1_mode_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      if (i_valid) begin
         s1_prod_d  = prod_c;
         s1_psum_d  = i_psum;
         s1_mode_d  = i_mode;
         s1_first_d = i_first;
         s1_last_d  = i_last;
      end
   end

   // Stage 2: saturating add. A first beat reloads from the bias, which is
   // also how a first inside an open frame discards the old partial.
   always_comb begin
      acc_base = s1_first_q ? (SUM_BW+1)'(s1_psum_q) : acc_q;
      pass_r   = sat_add(64'(s1_psum_q), 64'(s1_prod_q), OUT_BW);
      acc_r    = sat_add(64'(acc_base), 64'(s1_prod_q), OUT_BW);

      acc_d     = acc_q;
      sticky_d  = sticky_q;
      o_valid_d = 1'b0;
      o_psum_d  = o_psum_q;
      o_sat_d   = o_sat_q;

      if (s1_valid_q) begin
         if (s1_mode_q == MODE_PASS) begin
            o_valid_d = 1'b1;
            o_psum_d  = pass_r.val[SUM_BW:0];
            o_sat_d   = pass_r.sat;
         end else begin
            acc_d    = acc_r.val[SUM_BW:0];
            sticky_d = (s1_first_q ? 1'b0 : sticky_q) | acc_r.sat;
            if (s1_last_q) begin
               o_valid_d = 1'b1;
               o_psum_d  = acc_d;
               o_sat_d   = sticky_d;
            end
         end
      end
   end

   // Clamped values always fit in OUT_BW bits; the upper bits are sign copies.
   assign unused_hi_bits = ^{pass_r.val[63:SUM_BW+1], acc_r.val[63:SUM_BW+1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_psum_q  <= '0;
         s1_mode_q  <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         acc_q      <= '0;
         sticky_q   <= 1'b0;
         o_valid_q  <= 1'b0;
         o_psum_q   <= '0;
         o_sat_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_prod_q  <= s1_prod_d;
         s1_psum_q  <= s1_psum_d;
         s1_mode_q  <= s1_mode_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         acc_q      <= acc_d;
         sticky_q   <= sticky_d;
         o_valid_q  <= o_valid_d;
         o_psum_q   <= o_psum_d;
         o_sat_q    <= o_sat_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_psum  = o_psum_q;
   assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_processing_element_mc.sv
// ----------------------------------------------------------------------------
// tb_processing_element_mc
// Scoreboard bench: the stimulus side runs a reference model built from the
// arithmetic rules and queues each expected result with its due cycle; a
// negedge monitor pops and compares whenever o_valid is seen.
// ----------------------------------------------------------------------------
module tb_processing_element_mc;

   localparam int OUT_MAX = 65535;
   localparam int OUT_MIN = -65536;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_w_en = 1'b0;
   logic [4:0]        i_w_addr = '0;
   logic [1:0]        i_w_bank = '0;
   logic signed [7:0] i_w = '0;
   logic              i_valid = 1'b0;
   logic [1:0]        i_bank_sel = '0;
   logic              i_mode = 1'b0;
   logic              i_first = 1'b0;
   logic              i_last = 1'b0;
   logic signed [7:0] i_x = '0;
   logic signed [15:0] i_psum = '0;
   logic              o_valid;
   logic signed [16:0] o_psum;
   logic              o_sat;

   processing_element_mc #(
      .WEIGHT_BW(8), .DATA_BW(8), .SUM_BW(16), .ADDR_BW(5),
      .ELEMENT_ADDR(0), .NUM_BANKS(4), .BANK_BW(2)
   ) dut (
      .clk(clk), .rst(rst),
      .i_w_en(i_w_en), .i_w_addr(i_w_addr), .i_w_bank(i_w_bank), .i_w(i_w),
      .i_valid(i_valid), .i_bank_sel(i_bank_sel), .i_mode(i_mode),
      .i_first(i_first), .i_last(i_last), .i_x(i_x), .i_psum(i_psum),
      .o_valid(o_valid), .o_psum(o_psum), .o_sat(o_sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int psum;
      bit sat;
      int due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   wm[4];
   int   acc_m = 0;
   bit   sticky_m = 1'b0;
   int   last_psum = 0;
   bit   last_sat = 1'b0;

   function automatic int clampv(int v);
      if (v > OUT_MAX) return OUT_MAX;
      if (v < OUT_MIN) return OUT_MIN;
      return v;
   endfunction

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (o_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("psum", int'(o_psum), e.psum);
               check("sat", int'(o_sat), int'(e.sat));
               check("latency", cyc, e.due);
               last_psum = e.psum;
               last_sat  = e.sat;
            end
         end else begin
            check("hold_psum", int'(o_psum), last_psum);
            check("hold_sat", int'(o_sat), int'(last_sat));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               check("missing_valid", 0, 1);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Apply the model to the inputs now on the bus, then advance one cycle.
   task automatic step();
      int   w;
      int   prod;
      int   s;
      exp_t e;
      if (rst) begin
         for (int i = 0; i < 4; i++) wm[i] = 0;
         acc_m = 0;
         sticky_m = 1'b0;
         sb.delete();
         last_psum = 0;
         last_sat = 1'b0;
      end else begin
         if (i_valid) begin
            w    = (int'(i_bank_sel) < 4) ? wm[i_bank_sel] : 0;
            prod = w * int'(i_x);
            if (!i_mode) begin
               s = int'(i_psum) + prod;
               e.psum = clampv(s);
               e.sat  = (s != e.psum);
               e.due  = cyc + 2;
               sb.push_back(e);
            end else begin
               s = (i_first ? int'(i_psum) : acc_m) + prod;
               acc_m = clampv(s);
               sticky_m = (i_first ? 1'b0 : sticky_m) | (s != acc_m);
               if (i_last) begin
                  e.psum = acc_m;
                  e.sat  = sticky_m;
                  e.due  = cyc + 2;
                  sb.push_back(e);
               end
            end
         end
         // Weight writes land after the beat read: old value used this cycle.
         if (i_w_en && i_w_addr == 5'd0 && int'(i_w_bank) < 4)
            wm[i_w_bank] = int'(i_w);
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_w_en  = 1'b0;
      i_first = 1'b0;
      i_last  = 1'b0;
      i_mode  = 1'b0;
   endtask

   task automatic set_wr(int bank, int val, int addr = 0);
      i_w_en   = 1'b1;
      i_w_addr = 5'(addr);
      i_w_bank = 2'(bank);
      i_w      = 8'(val);
   endtask

   task automatic set_beat(int bank, bit mode, bit first, bit last, int x, int psum);
      i_valid    = 1'b1;
      i_bank_sel = 2'(bank);
      i_mode     = mode;
      i_first    = first;
      i_last     = last;
      i_x        = 8'(x);
      i_psum     = 16'(psum);
   endtask

   task automatic wr(int bank, int val, int addr = 0);
      set_wr(bank, val, addr);
      step();
   endtask

   task automatic beat(int bank, bit mode, bit first, bit last, int x, int psum);
      set_beat(bank, mode, first, last, x, psum);
      step();
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      check("rst_o_valid", int'(o_valid), 0);
      check("rst_o_psum", int'(o_psum), 0);
      check("rst_o_sat", int'(o_sat), 0);
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Bank load / read
      wr(0, 3);
      wr(1, -2);
      beat(0, 0, 0, 0, 5, 10);
      beat(1, 0, 0, 0, 5, 10);
      idle(3);

      // Addressing: foreign element address ignored
      wr(0, 55, 1);
      wr(2, 99, 31);
      beat(0, 0, 0, 0, 1, 0);
      beat(2, 0, 0, 0, 1, 0);
      // Same-cycle write hazard: old weight 3 used, then 7
      set_wr(0, 7);
      set_beat(0, 0, 0, 0, 1, 20);
      step();
      beat(0, 0, 0, 0, 1, 20);
      wr(0, 3);
      idle(3);

      // Accumulate frame with bubbles: 100 + 3*(1+2+3+4) = 130
      beat(0, 1, 1, 0, 1, 100);
      idle(1);
      beat(0, 1, 0, 0, 2, 0);
      idle(2);
      beat(0, 1, 0, 0, 3, 0);
      beat(0, 1, 0, 1, 4, 0);
      idle(3);

      // Saturation high, low, then a clean frame clears the sticky flag
      wr(2, 127);
      wr(3, -128);
      for (int i = 0; i < 5; i++) beat(2, 1, i == 0, i == 4, 127, 0);
      for (int i = 0; i < 5; i++) beat(3, 1, i == 0, i == 4, 127, 0);
      for (int i = 0; i < 3; i++) beat(0, 1, i == 0, i == 2, 2, -7);
      idle(3);

      // Mixed modes: pass beat inside an open accumulate frame
      wr(1, 2);
      beat(0, 1, 1, 0, 1, 0);
      beat(1, 0, 0, 0, 4, 1);
      beat(0, 1, 0, 1, 2, 0);
      idle(3);

      // First mid-frame discards the old partial
      beat(0, 1, 1, 0, 5, 1000);
      beat(0, 1, 0, 0, 5, 0);
      beat(0, 1, 1, 0, 1, 0);
      beat(0, 1, 0, 1, 1, 0);
      idle(3);

      // Reset inside an open frame; weights must read back as 0
      beat(0, 1, 1, 0, 2, 0);
      beat(0, 1, 0, 0, 2, 0);
      do_reset();
      for (int b = 0; b < 4; b++) beat(b, 0, 0, 0, 7, 5);
      idle(3);
      wr(0, 4);
      beat(0, 1, 0, 1, 3, 0);   // non-first beat after reset accumulates onto 0
      beat(0, 1, 1, 0, 3, 11);
      beat(0, 1, 0, 1, -6, 0);
      idle(3);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0)
            set_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) != 0)
            set_beat(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 65535)) - 32768);
         step();
      end
      idle(4);
      check("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
